// File: rtl/echo_pulse_meter.sv
// echo_pulse_meter: ultrasonic ranging controller.
// Sends a trigger pulse, waits for the echo line to rise, then measures how
// long it stays high in microseconds and centimetres.
// Optional build macro ECHO_SYNC_EN: when defined, echo passes through a
// 2-flop synchronizer before edge detection. That adds 2 cycles of detection
// latency, but the measured values stay the same. When undefined, echo must
// be driven synchronously to clk.
module echo_pulse_meter #(
  parameter int CLK_PER_US = 125,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int US_PER_CM  = 58
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] width_us,
  output logic [9:0]  dist_cm
);

  localparam int TRIG_CYC = TRIG_US * CLK_PER_US;
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int TW = (TRIG_CYC > 1) ? $clog2(TRIG_CYC) : 1;
  localparam int CW = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_PER_US - 1);
  localparam logic [TW-1:0] TRIG_MAX    = TW'(TRIG_CYC - 1);
  localparam logic [CW-1:0] CM_SUB_MAX  = CW'(US_PER_CM - 1);
  localparam logic [15:0]   TIMEOUT_LIM = 16'(TIMEOUT_US);
  localparam logic [9:0]    CM_SAT      = 10'd1023;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE
  } state_t;

  state_t state, state_d;

  logic [PW-1:0] presc;
  logic [TW-1:0] trig_cnt;
  logic [15:0]   us_cnt;
  logic [CW-1:0] cm_sub;
  logic [9:0]    cm_cnt;

  logic          echo_s;
  logic          echo_q;
  logic          echo_rise;
  logic          echo_fall;

  logic          us_tick;
  logic [15:0]   us_next;
  logic          sub_wrap;
  logic [9:0]    cm_next;
  logic          timeout_hit;
  logic          entering;
  logic          done_d;
  logic          timeout_d;
  logic          latch_d;

`ifdef ECHO_SYNC_EN
  logic sync1, sync2;

  // Two-flop synchronizer bringing the asynchronous echo line into clk.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= echo;
      sync2 <= sync1;
    end
  end

  assign echo_s = sync2;
`else
  assign echo_s = echo;
`endif

  // Edge-detect register. It runs in every state, so an echo that is already
  // high when WAIT_RISE is entered does not look like a rising edge.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) echo_q <= 1'b0;
    else         echo_q <= echo_s;
  end

  assign echo_rise = echo_s & ~echo_q;
  assign echo_fall = ~echo_s & echo_q;

  // Values include the tick pending this cycle, so a latch on the terminating
  // edge sees the final microsecond.
  assign us_tick     = (presc == PRESC_MAX);
  assign us_next     = us_cnt + {15'd0, us_tick};
  assign sub_wrap    = us_tick && (cm_sub == CM_SUB_MAX);
  assign cm_next     = (sub_wrap && (cm_cnt != CM_SAT)) ? cm_cnt + 10'd1 : cm_cnt;
  assign timeout_hit = (us_next == TIMEOUT_LIM);
  assign busy        = (state != IDLE);
  assign entering    = (state_d != state);

  // Next-state and terminal-event decode. An echo fall wins over a timeout
  // that lands on the same edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d   = state;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    latch_d   = 1'b0;
    case (state)
      IDLE: begin
        // A start is rejected while a done/timeout pulse is still on the outputs.
        if (start && !done && !timeout) state_d = TRIG;
      end
      TRIG: begin
        if (trig_cnt == TRIG_MAX) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d = MEASURE;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          state_d = IDLE;
          done_d  = 1'b1;
          latch_d = 1'b1;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge, whatever the statement order.
    if (reset_p) begin
      state    <= IDLE;
      trig     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      width_us <= 16'd0;
      dist_cm  <= 10'd0;
    end else begin
      state   <= state_d;
      trig    <= (state_d == TRIG);
      done    <= done_d;
      timeout <= timeout_d;
      if (latch_d) begin
        width_us <= us_next;
        dist_cm  <= cm_next;
      end
    end
  end

  // Microsecond prescaler, restarted on every state entry.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)                  presc <= '0;
    else if (entering || us_tick) presc <= '0;
    else                          presc <= presc + PW'(1);
  end

  // Trigger width counter, active only while in TRIG.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)                         trig_cnt <= '0;
    else if (entering || state != TRIG)  trig_cnt <= '0;
    else                                 trig_cnt <= trig_cnt + TW'(1);
  end

  // Microsecond counter for the rise wait and the echo width. It never passes
  // TIMEOUT_US, because the FSM leaves when it gets there.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      us_cnt <= 16'd0;
    else if (entering)
      us_cnt <= 16'd0;
    else if (us_tick && (state == WAIT_RISE || state == MEASURE))
      us_cnt <= us_next;
  end

  // Centimetre sub-counter and saturating centimetre counter.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cm_sub <= '0;
      cm_cnt <= 10'd0;
    end else if (entering) begin
      cm_sub <= '0;
      cm_cnt <= 10'd0;
    end else if (state == MEASURE && us_tick) begin
      cm_sub <= sub_wrap ? '0 : cm_sub + CW'(1);
      cm_cnt <= cm_next;
    end
  end

endmodule

// File: doc/echo_pulse_meter.md
ECHO_PULSE_METER -- requirements
Module: echo_pulse_meter

Interface
REQ-001 Parameter CLK_PER_US, default 125, clk cycles per microsecond (125 MHz system clock).
REQ-002 Parameter TRIG_US, default 10, trigger pulse width in microseconds.
REQ-003 Parameter TIMEOUT_US, default 30000, maximum microseconds to wait for an echo rise and maximum echo-high time (range 1..65535).
REQ-004 Parameter US_PER_CM, default 58, microseconds of echo-high time per centimetre.
REQ-005 clk  input  1  system clock; all logic is on the rising edge.
REQ-006 reset_p  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a measurement.
REQ-008 echo  input  1  asynchronous echo line from the sensor.
REQ-009 trig  output  1  trigger pulse to the sensor.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when a valid measurement is latched.
REQ-012 timeout  output  1  one-cycle pulse when a measurement is aborted.
REQ-013 width_us  output  16  latched echo-high width in microseconds.
REQ-014 dist_cm  output  10  latched distance in centimetres.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, TRIG, WAIT_RISE and MEASURE.
REQ-016 In IDLE, start=1 SHALL move the FSM to TRIG on the next edge; start SHALL be ignored in every other state.
REQ-017 trig SHALL be registered, and SHALL be high for exactly TRIG_US*CLK_PER_US cycles (1250 at defaults) starting the cycle after start is sampled; the FSM SHALL then enter WAIT_RISE.
REQ-018 An internal prescaler SHALL count 0..CLK_PER_US-1 and emit a 1-cycle us_tick at CLK_PER_US-1; the prescaler SHALL be cleared on every state entry.
REQ-019 The us counter SHALL be cleared on entry to WAIT_RISE and to MEASURE, and SHALL increment on each us_tick.
REQ-020 In WAIT_RISE, a rising edge of the (synchronized) echo SHALL move the FSM to MEASURE; an echo already high on entry SHALL NOT count as a rise.
REQ-021 In MEASURE, a cm sub-counter SHALL count us_ticks 0..US_PER_CM-1, and the cm counter SHALL increment when the sub-counter wraps.
REQ-022 In MEASURE, a falling edge of echo SHALL cause the following, all in one edge:
  - width_us latched from the us counter;
  - dist_cm latched from the cm counter (truncated: partial centimetres are dropped);
  - done pulsed for one cycle;
  - return to IDLE.
REQ-023 If the us counter reaches TIMEOUT_US in WAIT_RISE or MEASURE, the block SHALL:
  - pulse timeout for one cycle;
  - return to IDLE;
  - leave width_us and dist_cm unchanged.
REQ-024 If an echo fall and the timeout occur in the same cycle, the echo fall SHALL take priority.
REQ-025 Counters SHALL NOT wrap: TIMEOUT_US ≤ 65535 bounds the us counter, and the cm counter SHALL saturate at 1023.
REQ-026 done and timeout SHALL never be high in the same cycle.
REQ-027 A start pulse in the same cycle as done or timeout SHALL be ignored; start is accepted only while already in IDLE.

Reset
REQ-028 While reset_p is high, the block SHALL hold the following, independent of clk:
  - FSM in IDLE;
  - all counters at 0;
  - trig=0, busy=0, done=0, timeout=0;
  - width_us=0, dist_cm=0;
  - synchronizer flops at 0.
REQ-029 A reset asserted mid-measurement SHALL abort it; no done or timeout SHALL be issued.
REQ-030 After reset_p is released, the block SHALL accept a start on the first clk edge.

Configuration
REQ-031 Macro ECHO_SYNC_EN selects how echo reaches the edge detector:
  - defined: echo passes through a 2-flop synchronizer before the edge-detect register, adding exactly 2 cycles of latency to rise/fall detection;
  - undefined: echo feeds the edge-detect register directly (1-cycle detection) and SHALL only be driven synchronously to clk.
REQ-032 Measured width_us and dist_cm SHALL be identical with and without ECHO_SYNC_EN; only the detection timing shifts.

Verification
REQ-033 Start at IDLE → trig high for exactly 1250 cycles; busy rises one cycle after start.
REQ-034 Echo rises 200 us after trig falls and stays high 580 us (72500 cycles) → done pulse, width_us=580, dist_cm=10, back in IDLE.
REQ-035 Echo high 1000 us → width_us=1000, dist_cm=17 (truncated).
REQ-036 No echo after trig → timeout pulse 30000 us after WAIT_RISE entry; width_us and dist_cm keep their previous values (580/10).
REQ-037 Echo stuck high from before trig → no rise detected → timeout; second start while busy → ignored (no extra trig).
REQ-038 reset_p pulsed 100 us into MEASURE → all outputs 0, no done; the next start runs a clean measurement.
